// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Helpers work on 32-bit values; callers cast to and from their own DIV_W.
package clk_div_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StStop
   } state_e;

   localparam int unsigned MIN_DIV   = 2;
   localparam int unsigned DIV_MAX_W = 32;

   // Divisors below MIN_DIV cannot form a high and a low phase, so they are raised.
   function automatic logic [DIV_MAX_W-1:0] clamp_div(input logic [DIV_MAX_W-1:0] d);
      return (d < MIN_DIV) ? DIV_MAX_W'(MIN_DIV) : d;
   endfunction

   // High-phase length ceil(n/2), written so it cannot overflow at the top of the range.
   function automatic logic [DIV_MAX_W-1:0] half_div(input logic [DIV_MAX_W-1:0] n);
      return (n >> 1) + {{(DIV_MAX_W-1){1'b0}}, n[0]};
   endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle between a programmable clock divider and its controller.
interface clk_div_prog_if #(
   parameter int unsigned DIV_W = 8
);
   logic             enable;
   logic [DIV_W-1:0] div_in;
   logic             div_wr;
   logic             clk_out;
   logic             tick;
   logic             running;
   logic             div_pending;
   logic [DIV_W-1:0] cur_div;

   modport master (
      output enable, div_in, div_wr,
      input  clk_out, tick, running, div_pending, cur_div
   );

   modport slave (
      input  enable, div_in, div_wr,
      output clk_out, tick, running, div_pending, cur_div
   );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor and enable changes.
// clk_out and tick are registered; every change takes effect only on a period boundary.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W       = 8,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input logic           clk_in,
   input logic           reset,
   clk_div_prog_if.slave bus
);

   localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] One    = DIV_W'(1);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic [DIV_W-1:0] cur_div_q, cur_div_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             pend_q, pend_d;

   logic             wrap;
   logic             take_pend;
   logic [DIV_W-1:0] div_eff;

   assign wrap = (state_q != StIdle) && (cnt_q == cur_div_q - One);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
         cur_div_q  <= DefDiv;
         pend_div_q <= DefDiv;
         pend_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
         cur_div_q  <= cur_div_d;
         pend_div_q <= pend_div_d;
         pend_q     <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (bus.enable) state_d = StRun;
         StRun:  if (!bus.enable) state_d = StStop;
         StStop: begin
            if (bus.enable) begin
               state_d = StRun;
            end else if (wrap) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      clk_out_d  = clk_out_q;
      tick_d     = 1'b0;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      pend_d     = pend_q;
      take_pend  = 1'b0;
      div_eff    = cur_div_q;

      unique case (state_q)
         StIdle: begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            if (bus.enable) begin
               take_pend = pend_q;
               clk_out_d = 1'b1;
               tick_d    = 1'b1;
            end
         end
         StRun, StStop: begin
            take_pend = wrap && pend_q;
            if (state_q == StStop && !bus.enable && wrap) begin
               cnt_d     = '0;
               clk_out_d = 1'b0;
            end else begin
               // A divisor applied at this wrap already shapes the period it starts.
               div_eff   = take_pend ? pend_div_q : cur_div_q;
               cnt_d     = wrap ? '0 : cnt_q + One;
               clk_out_d = DIV_MAX_W'(cnt_d) < half_div(DIV_MAX_W'(div_eff));
               tick_d    = (cnt_d == '0);
            end
         end
         default: begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
         end
      endcase

      if (take_pend) begin
         cur_div_d = pend_div_q;
         pend_d    = 1'b0;
      end
      // A write on a wrap edge lands after the old pending value was consumed.
      if (bus.div_wr) begin
         pend_div_d = DIV_W'(clamp_div(DIV_MAX_W'(bus.div_in)));
         pend_d     = 1'b1;
      end
   end

   assign bus.clk_out     = clk_out_q;
   assign bus.tick        = tick_q;
   assign bus.running     = (state_q != StIdle);
   assign bus.div_pending = pend_q;
   assign bus.cur_div     = cur_div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: per-edge vector table plus hand-written reset sequence.
module tb_clk_div_prog;

   localparam int unsigned DIV_W = 8;

   typedef struct {
      logic             en;
      logic             wr;
      logic [DIV_W-1:0] din;
      logic             clk;
      logic             tick;
      logic             run;
      logic             pend;
      logic [DIV_W-1:0] cur;
   } vec_t;

   logic clk_in = 1'b0;
   logic reset;
   vec_t vecs[$];
   int   n_pass  = 0;
   int   n_total = 0;

   clk_div_prog_if #(.DIV_W(DIV_W)) bus ();

   clk_div_prog #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(2)
   ) dut (
      .clk_in(clk_in),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
   endtask

   task automatic check_outs(input int idx, input logic c, input logic t, input logic r,
                             input logic p, input logic [DIV_W-1:0] cur);
      check("clk_out", idx, 32'(bus.clk_out), 32'(c));
      check("tick", idx, 32'(bus.tick), 32'(t));
      check("running", idx, 32'(bus.running), 32'(r));
      check("div_pending", idx, 32'(bus.div_pending), 32'(p));
      check("cur_div", idx, 32'(bus.cur_div), 32'(cur));
   endtask

   task automatic step(input logic en, input logic wr, input logic [DIV_W-1:0] din);
      bus.enable = en;
      bus.div_wr = wr;
      bus.div_in = din;
      @(posedge clk_in);
      #1;
      bus.div_wr = 1'b0;
   endtask

   function automatic void add(input logic en, input logic wr, input int din, input logic c,
                               input logic t, input logic r, input logic p, input int cur);
      vec_t v;
      v.en   = en;
      v.wr   = wr;
      v.din  = DIV_W'(din);
      v.clk  = c;
      v.tick = t;
      v.run  = r;
      v.pend = p;
      v.cur  = DIV_W'(cur);
      vecs.push_back(v);
   endfunction

   initial begin
      //  en wr din | clk tick run pend cur
      // Divide-by-2 from enable
      add(1, 0, 0,  1, 1, 1, 0, 2);
      add(1, 0, 0,  0, 0, 1, 0, 2);
      add(1, 0, 0,  1, 1, 1, 0, 2);
      // Write 5 mid-period, applied at the next wrap
      add(1, 1, 5,  0, 0, 1, 1, 2);
      add(1, 0, 0,  1, 1, 1, 0, 5);
      add(1, 0, 0,  1, 0, 1, 0, 5);
      add(1, 0, 0,  1, 0, 1, 0, 5);
      add(1, 0, 0,  0, 0, 1, 0, 5);
      add(1, 0, 0,  0, 0, 1, 0, 5);
      // Write 3 on a wrap edge: one more N=5 period first
      add(1, 1, 3,  1, 1, 1, 1, 5);
      add(1, 0, 0,  1, 0, 1, 1, 5);
      add(1, 0, 0,  1, 0, 1, 1, 5);
      add(1, 0, 0,  0, 0, 1, 1, 5);
      add(1, 0, 0,  0, 0, 1, 1, 5);
      add(1, 0, 0,  1, 1, 1, 0, 3);
      add(1, 0, 0,  1, 0, 1, 0, 3);
      add(1, 0, 0,  0, 0, 1, 0, 3);
      add(1, 0, 0,  1, 1, 1, 0, 3);
      // Writes of 0 then 1 clamp to 2
      add(1, 1, 0,  1, 0, 1, 1, 3);
      add(1, 1, 1,  0, 0, 1, 1, 3);
      add(1, 0, 0,  1, 1, 1, 0, 2);
      add(1, 0, 0,  0, 0, 1, 0, 2);
      add(1, 0, 0,  1, 1, 1, 0, 2);
      add(1, 1, 0,  0, 0, 1, 1, 2);
      add(1, 0, 0,  1, 1, 1, 0, 2);
      // N=5, enable dropped in the 2nd cycle: period completes, then idle
      add(1, 1, 5,  0, 0, 1, 1, 2);
      add(1, 0, 0,  1, 1, 1, 0, 5);
      add(1, 0, 0,  1, 0, 1, 0, 5);
      add(0, 0, 0,  1, 0, 1, 0, 5);
      add(0, 0, 0,  0, 0, 1, 0, 5);
      add(0, 0, 0,  0, 0, 1, 0, 5);
      add(0, 0, 0,  0, 0, 0, 0, 5);
      add(0, 0, 0,  0, 0, 0, 0, 5);
      // Restart, then a brief STOP that must not disturb the period
      add(1, 0, 0,  1, 1, 1, 0, 5);
      add(1, 0, 0,  1, 0, 1, 0, 5);
      add(0, 0, 0,  1, 0, 1, 0, 5);
      add(1, 0, 0,  0, 0, 1, 0, 5);
      add(1, 0, 0,  0, 0, 1, 0, 5);
      add(1, 0, 0,  1, 1, 1, 0, 5);

      reset      = 1'b1;
      bus.enable = 1'b0;
      bus.div_wr = 1'b0;
      bus.div_in = '0;
      repeat (2) @(posedge clk_in);
      #1;
      check_outs(-1, 0, 0, 0, 0, 2);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].en, vecs[i].wr, vecs[i].din);
         check_outs(i, vecs[i].clk, vecs[i].tick, vecs[i].run, vecs[i].pend, vecs[i].cur);
      end

      // Move to N=7, then hit reset in the high phase between edges
      step(1, 1, 7);
      check_outs(100, 1, 0, 1, 1, 5);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      check_outs(101, 0, 0, 1, 1, 5);
      step(1, 0, 0);
      check_outs(102, 1, 1, 1, 0, 7);
      step(1, 0, 0);
      check_outs(103, 1, 0, 1, 0, 7);
      #2;
      reset = 1'b1;
      #1;
      check_outs(104, 0, 0, 0, 0, 2);
      @(posedge clk_in);
      #1;
      reset = 1'b0;
      step(1, 0, 0);
      check_outs(105, 1, 1, 1, 0, 2);
      step(1, 0, 0);
      check_outs(106, 0, 0, 1, 0, 2);
      step(1, 0, 0);
      check_outs(107, 1, 1, 1, 0, 2);
      step(1, 0, 0);
      check_outs(108, 0, 0, 1, 0, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
